aw_burst_engine: RTL and testbench

//   AXI4 write-address engine for the DMA write path. Splits a (start_addr, btt) request into INCR bursts,

---
 rtl/aw_burst_if.sv | 23 ++
 rtl/aw_burst_engine.sv | 152 +++++++++++++++
 tb/tb_aw_burst_engine.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aw_burst_if.sv
// AXI4 write-address channel bundle shared by the burst engine and its slave.
interface aw_burst_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [ID_WIDTH-1:0]   awid;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready
  );
endinterface

// File: rtl/aw_burst_engine.sv
// AXI4 write-address engine: splits a (start_addr, btt) request into INCR bursts that never
// cross a 4 KB page, limits in-flight bursts with a B-response credit counter and can lock-step
// AW issue with the W data engine.
module aw_burst_engine #(
  parameter int unsigned AXI_ADDR_WIDTH                  = 64,
  parameter int unsigned AXI_DATA_WIDTH                  = 512,
  parameter int unsigned AXI_MAX_AWLEN                   = 64,
  parameter int unsigned AXI_ID_WIDTH                    = 4,
  parameter int unsigned AXI_ID                          = 0,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET   = '0,
  parameter int unsigned INTERNAL_ADDR_WIDTH             = 32,
  parameter int unsigned BTT_WIDTH                       = 24,
  parameter bit          SYNC_AW_W                       = 1'b0,
  parameter int unsigned MAX_OUTSTANDING                 = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [INTERNAL_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [BTT_WIDTH-1:0]           btt_i,
  input  logic                           enable_i,
  input  logic                           writer_fifo_empty_i,
  input  logic                           write_zero_i,
  input  logic                           w_sync_i,
  input  logic                           b_done_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           new_transaction_o,
  output logic                           last_transaction_o,
  output logic                           aw_sync_o,
  aw_burst_if.master                     aw
);

  localparam int unsigned Bytes   = AXI_DATA_WIDTH / 8;
  localparam int unsigned OffBits = $clog2(Bytes);
  localparam int unsigned AddrW   = INTERNAL_ADDR_WIDTH;
  localparam int unsigned RemW    = BTT_WIDTH + 1;
  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {StIdle, StWait1, StSendAw, StWSync, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [OutW-1:0]   out_q, out_d;

  logic        awvalid;
  logic        hs;
  logic        last;
  logic        b_dec;
  logic        data_ok;
  logic        can_issue;
  logic [12:0] page_beats;
  logic [31:0] cap;

  assign hs         = awvalid && aw.awready;
  assign last       = (RemW'(beats_q) == rem_q);
  // Beats left before the next 4 KB page; the address is always beat-aligned.
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> OffBits;
  assign data_ok    = !SYNC_AW_W || !writer_fifo_empty_i || write_zero_i;
  assign can_issue  = enable_i && (out_q < OutW'(MAX_OUTSTANDING)) && data_ok;
  // A B response with nothing in flight is stale and must not underflow the counter.
  assign b_dec      = b_done_i && (out_q != '0);

  // Burst length: smallest of remaining beats, AXI cap and room left in the page.
  always_comb begin
    cap = 32'(AXI_MAX_AWLEN);
    if (32'(page_beats) < cap) cap = 32'(page_beats);
    if (32'(rem_q) < cap)      cap = 32'(rem_q);
  end

  // Credit counter: one per accepted AW, returned by each B response.
  always_comb begin
    out_d = out_q;
    if (hs && !b_dec)      out_d = out_q + OutW'(1);
    else if (!hs && b_dec) out_d = out_q - OutW'(1);
  end

  // Request FSM next-state, address/remaining bookkeeping and handshake outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    awvalid = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = start_addr_i & ~AddrW'(Bytes - 1);
          rem_d   = ({1'b0, btt_i} + RemW'(Bytes - 1)) >> OffBits;
          state_d = (btt_i == '0) ? StDrain : StWait1;
        end
      end
      StWait1: begin
        beats_d = 9'(cap);
        if (can_issue) state_d = StSendAw;
      end
      StSendAw: begin
        awvalid = 1'b1;
        if (aw.awready) begin
          addr_d = addr_q + (AddrW'(beats_q) << OffBits);
          rem_d  = rem_q - RemW'(beats_q);
          if (last)                        state_d = StDrain;
          else if (SYNC_AW_W && !w_sync_i) state_d = StWSync;
          else                             state_d = StWait1;
        end
      end
      StWSync: begin
        if (w_sync_i) state_d = StWait1;
      end
      StDrain: begin
        if (out_d == '0) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; in-flight credits are dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      out_q   <= out_d;
    end
  end

  assign busy_o             = (state_q != StIdle);
  assign new_transaction_o  = hs;
  assign last_transaction_o = (state_q == StSendAw) && last;
  assign aw_sync_o          = hs || (state_q == StWSync);

  assign aw.awvalid = awvalid;
  assign aw.awaddr  = AXI_ADDR_OFFSET | AXI_ADDR_WIDTH'(addr_q);
  assign aw.awlen   = 8'(beats_q - 9'd1);
  assign aw.awsize  = 3'(OffBits);
  assign aw.awburst = 2'b01;
  assign aw.awid    = AXI_ID_WIDTH'(AXI_ID);

endmodule

// File: tb/tb_aw_burst_engine.sv
// Bench for aw_burst_engine: a free-running instance (4 credits) checked against a burst-list
// model, plus a lock-step instance (SYNC_AW_W=1, 2 credits) sharing the same inputs.
module tb_aw_burst_engine;

  localparam int unsigned MaxA = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [23:0] btt = '0;
  logic        enable = 1'b1;
  logic        fifo_empty = 1'b0;
  logic        write_zero = 1'b0;
  logic        w_sync = 1'b1;
  logic        b_done = 1'b0;
  logic        awready = 1'b1;

  logic busy_a, done_a, nt_a, lt_a, async_a;
  logic busy_s, done_s, nt_s, lt_s, async_s;

  int checks = 0;
  int errors = 0;

  aw_burst_if #(.ADDR_WIDTH(64), .ID_WIDTH(4)) if_a ();
  aw_burst_if #(.ADDR_WIDTH(64), .ID_WIDTH(4)) if_s ();

  assign if_a.awready = awready;
  assign if_s.awready = awready;

  always #5 clk = ~clk;

  aw_burst_engine #(.MAX_OUTSTANDING(MaxA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr), .btt_i(btt),
    .enable_i(enable), .writer_fifo_empty_i(fifo_empty), .write_zero_i(write_zero),
    .w_sync_i(w_sync), .b_done_i(b_done), .busy_o(busy_a), .done_o(done_a),
    .new_transaction_o(nt_a), .last_transaction_o(lt_a), .aw_sync_o(async_a), .aw(if_a)
  );

  aw_burst_engine #(.SYNC_AW_W(1'b1), .MAX_OUTSTANDING(2)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr), .btt_i(btt),
    .enable_i(enable), .writer_fifo_empty_i(fifo_empty), .write_zero_i(write_zero),
    .w_sync_i(w_sync), .b_done_i(b_done), .busy_o(busy_s), .done_o(done_s),
    .new_transaction_o(nt_s), .last_transaction_o(lt_s), .aw_sync_o(async_s), .aw(if_s)
  );

  task automatic set_defaults();
    start = 1'b0; enable = 1'b1; fifo_empty = 1'b0; write_zero = 1'b0;
    w_sync = 1'b1; b_done = 1'b0; awready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_defaults();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One-cycle start strobe; returns at posedge+1 of the first cycle after acceptance.
  task automatic kick(input logic [31:0] addr, input int unsigned bytes);
    start = 1'b1; start_addr = addr; btt = 24'(bytes);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({if_a.awvalid, busy_a, done_a, nt_a, async_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_a: got %b want 00000", {if_a.awvalid, busy_a, done_a, nt_a, async_a});
    end
    checks++;
    if ({if_s.awvalid, busy_s, done_s, nt_s, async_s} !== 5'b0) begin
      errors++;
      $display("FAIL reset_s: got %b want 00000", {if_s.awvalid, busy_s, done_s, nt_s, async_s});
    end
    checks++;
    if ({if_a.awsize, if_a.awburst, if_a.awid} !== {3'd6, 2'b01, 4'd0}) begin
      errors++;
      $display("FAIL const_fields: got size %0d burst %0d id %0d want 6 1 0",
               if_a.awsize, if_a.awburst, if_a.awid);
    end
    @(posedge clk); #1;
  endtask

  // Drives one request on instance A and scores every AW, credit and done against a burst list
  // derived from the page/length rules; rnd randomizes awready, enable and B timing.
  task automatic run_request(input logic [31:0] addr, input int unsigned bytes, input bit rnd);
    logic [31:0] exp_addr[$];
    int unsigned exp_len[$];
    logic [31:0] a;
    int unsigned rem, room, b, nbursts, out, cyc, nt_cnt, sync_cnt;
    bit issued_all, got_done, hs, exp_done;
    a = addr & 32'hFFFF_FFC0;
    rem = (bytes + 63) / 64;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 64;
      b = rem;
      if (b > 64) b = 64;
      if (b > room) b = room;
      exp_addr.push_back(a);
      exp_len.push_back(b);
      a = a + 32'(b * 64);
      rem = rem - b;
    end
    nbursts = exp_addr.size();
    out = 0; cyc = 0; nt_cnt = 0; sync_cnt = 0;
    issued_all = (nbursts == 0);
    got_done = 1'b0;
    kick(addr, bytes);
    while (!got_done && cyc < 8000) begin
      if (rnd) begin
        awready = ($urandom_range(0, 3) != 0);
        enable  = ($urandom_range(0, 3) != 0);
        b_done  = (out > 0) && ($urandom_range(0, 2) == 0);
      end else begin
        awready = 1'b1; enable = 1'b1;
        b_done  = (out > 0);
      end
      @(negedge clk);
      cyc++;
      hs = if_a.awvalid && awready;
      if (nt_a) nt_cnt++;
      if (async_a) sync_cnt++;
      checks++;
      if (busy_a !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_request: got %b want 1 (cycle %0d)", busy_a, cyc);
      end
      if (if_a.awvalid) begin
        checks++;
        if (out >= MaxA) begin
          errors++;
          $display("FAIL credit_bound: awvalid with %0d outstanding, want < %0d", out, MaxA);
        end
      end
      if (hs) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL extra_aw: got aw addr %h want none", if_a.awaddr);
        end else begin
          if ({if_a.awaddr, if_a.awlen, lt_a} !==
              {32'h0, exp_addr[0], 8'(exp_len[0] - 1), exp_addr.size() == 1}) begin
            errors++;
            $display("FAIL aw_burst: got addr %h len %0d last %b want addr %h len %0d last %b",
                     if_a.awaddr, if_a.awlen, lt_a, exp_addr[0], exp_len[0] - 1,
                     exp_addr.size() == 1);
          end
          void'(exp_addr.pop_front());
          void'(exp_len.pop_front());
        end
        out++;
      end
      if (b_done) out--;
      exp_done = issued_all && (out == 0);
      checks++;
      if (done_a !== exp_done) begin
        errors++;
        $display("FAIL done_timing: got %b want %b (cycle %0d)", done_a, exp_done, cyc);
      end
      if (exp_done) got_done = 1'b1;
      if (hs && exp_addr.size() == 0) issued_all = 1'b1;
      @(posedge clk); #1;
    end
    b_done = 1'b0; awready = 1'b1; enable = 1'b1;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL request_timeout: got no done after %0d cycles want done", cyc);
    end
    checks++;
    if (nt_cnt != nbursts || sync_cnt != nbursts) begin
      errors++;
      $display("FAIL aw_count: got new_transaction %0d aw_sync %0d want %0d",
               nt_cnt, sync_cnt, nbursts);
    end
    @(negedge clk);
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++;
      $display("FAIL post_done_idle: got busy,done %b want 00", {busy_a, done_a});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_reset();
    run_request(32'h0000_0000, 8192, 1'b0);  // two full 4 KB bursts
    run_request(32'h0000_0F80, 256, 1'b0);   // split at the page edge
    run_request(32'h0000_0123, 0, 1'b0);     // empty request
    run_request(32'hFFFF_FF00, 512, 1'b0);   // wraps the internal address space
    run_request(32'h0000_0FC0, 100, 1'b0);   // partial beat rounded up, one beat before edge
  endtask

  task automatic test_random();
    logic [31:0] addr;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      run_request(addr, $urandom_range(0, 12000), 1'b1);
    end
  endtask

  task automatic test_credit_limit();
    int unsigned na, ns;
    do_reset();
    na = 0; ns = 0;
    kick(32'h0, 24576);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nt_a) na++;
      if (nt_s) ns++;
    end
    checks++;
    if (na != 4 || ns != 2) begin
      errors++;
      $display("FAIL credit_stall: got aw counts %0d/%0d want 4/2", na, ns);
    end
    checks++;
    if ({if_a.awvalid, if_s.awvalid} !== 2'b00) begin
      errors++;
      $display("FAIL awvalid_no_credit: got %b want 00", {if_a.awvalid, if_s.awvalid});
    end
    @(posedge clk); #1;
    b_done = 1'b1;
    @(negedge clk);
    if (nt_a) na++;
    if (nt_s) ns++;
    @(posedge clk); #1;
    b_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nt_a) na++;
      if (nt_s) ns++;
    end
    checks++;
    if (na != 5 || ns != 3) begin
      errors++;
      $display("FAIL credit_return: got aw counts %0d/%0d want 5/3", na, ns);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sync();
    int unsigned nv, ns, nd;
    bit last_seen;
    do_reset();
    fifo_empty = 1'b1; write_zero = 1'b0; w_sync = 1'b0;
    nv = 0; ns = 0; last_seen = 1'b0;
    kick(32'h0, 8192);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_s.awvalid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL sync_fifo_empty: got %0d awvalid cycles want 0", nv);
    end
    @(posedge clk); #1;
    fifo_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nt_s) begin
        ns++;
        checks++;
        if (if_s.awaddr !== 64'h0) begin
          errors++;
          $display("FAIL sync_first_addr: got %h want 0", if_s.awaddr);
        end
      end
    end
    checks++;
    if (ns != 1 || async_s !== 1'b1) begin
      errors++;
      $display("FAIL sync_wait_w: got %0d aws aw_sync %b want 1 aws aw_sync 1", ns, async_s);
    end
    @(posedge clk); #1;
    w_sync = 1'b1;
    @(negedge clk);
    if (nt_s) ns++;
    @(posedge clk); #1;
    w_sync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nt_s) begin
        ns++;
        last_seen = lt_s;
      end
    end
    checks++;
    if (ns != 2 || !last_seen) begin
      errors++;
      $display("FAIL sync_release: got %0d aws last %b want 2 aws last 1", ns, last_seen);
    end
    // Zero-fill bypasses the FIFO-empty gate.
    do_reset();
    fifo_empty = 1'b1; write_zero = 1'b1; w_sync = 1'b1;
    ns = 0; nd = 0;
    kick(32'h0, 8192);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nt_s) ns++;
    end
    checks++;
    if (ns != 2) begin
      errors++;
      $display("FAIL write_zero_bypass: got %0d aws want 2", ns);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      b_done = (i < 2);
      @(negedge clk);
      if (done_s) nd++;
    end
    checks++;
    if (nd != 1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL sync_done: got %0d done pulses busy %b want 1 pulse busy 0", nd, busy_s);
    end
    @(posedge clk); #1;
    set_defaults();
  endtask

  task automatic test_reset_abort();
    int unsigned n, cyc;
    do_reset();
    n = 0; cyc = 0;
    kick(32'h0, 24576);
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (if_a.awvalid && awready) n++;
    end
    awready = 1'b0;
    cyc = 0;
    while (if_a.awvalid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (n != 3 || if_a.awvalid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: got %0d aws awvalid %b want 3 aws awvalid 1", n, if_a.awvalid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    awready = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_a.awvalid, busy_a, done_a} !== 3'b000) begin
      errors++;
      $display("FAIL abort_reset: got awvalid,busy,done %b want 000",
               {if_a.awvalid, busy_a, done_a});
    end
    @(posedge clk); #1;
    run_request(32'h2000_0F00, 1000, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_credit_limit();
    test_sync();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
